ext_feeder: RTL and testbench
=============================

EXT_FEEDER -- requirements
Module: ext_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ext_valid_in  input  1  external producer offers a sample.
REQ-006 SHALL have port ext_data_in  input  DATA_W  external sample, two's complement.
REQ-007 SHALL have port ext_ready_out  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port shift_in  input  1  controller dmem command equals DMEM_SHIFT; consumes the head sample.
REQ-009 SHALL have port extready_out  output  1  head sample valid; feeds the controller's extready_in.
REQ-010 SHALL have port sample_out  output  DATA_W  head sample presented to the data memory.
REQ-011 SHALL have port level_out  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port shift_err_out  output  1  sticky flag: shift_in seen while extready_out low.

Function
REQ-013 SHALL implement a DEPTH-entry circular buffer with write and read pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-014 SHALL push when ext_valid_in && ext_ready_out; the sample is stored at the write pointer.
REQ-015 SHALL pop when shift_in && extready_out; the read pointer advances.
REQ-016 SHALL keep level unchanged on a simultaneous push and pop; level SHALL never exceed DEPTH or go below 0.
REQ-017 SHALL register all outputs; ext_ready_out = (next level < DEPTH) and level_out = next level, both visible the cycle after the edge.
REQ-018 SHALL present a sample pushed into an empty buffer on sample_out with extready_out high exactly 1 cycle after the push.
REQ-019 SHALL hold sample_out stable while no pop occurs; after a pop, sample_out SHALL show the next entry the following cycle, or hold the last value if the buffer becomes empty.
REQ-020 SHALL ignore shift_in when extready_out is low: no pointer change, shift_err_out set to 1 and held until reset.
REQ-021 SHALL, when full, not accept a push because ext_ready_out is low; a simultaneous pop SHALL raise ext_ready_out the next cycle.
REQ-022 SHALL run FSM states PREFILL and RUN; reset enters PREFILL.
REQ-023 SHALL in PREFILL hold extready_out low regardless of level; transition PREFILL -> RUN when level reaches DEPTH.
REQ-024 SHALL in RUN drive extready_out = (next level != 0); RUN SHALL remain RUN until reset, including when the buffer empties.

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear both pointers and level, and set state PREFILL, ext_ready_out 0, extready_out 0, sample_out 0, level_out 0, shift_err_out 0.
REQ-026 SHALL assert ext_ready_out 1 cycle after rst deasserts.
REQ-027 SHALL discard buffered samples on a reset asserted mid-operation; no push or pop SHALL take effect on a cycle with rst high.

Configuration
REQ-028 SHALL support macro EXT_FEEDER_PREFILL_EN: when defined, REQ-022..REQ-024 apply.
REQ-029 SHALL, without EXT_FEEDER_PREFILL_EN, omit the FSM and drive extready_out = (next level != 0) from reset onward.

Verification
REQ-030 SHALL cover prefill (macro on, DEPTH=4): push 0x0001..0x0004 on consecutive cycles -> extready_out low through the third push and high 1 cycle after the fourth; sample_out=0x0001; ext_ready_out low.
REQ-031 SHALL cover in-order drain: from full, 4 consecutive shifts -> sample_out 0x0002, 0x0003, 0x0004 in turn, then extready_out low and level_out 0.
REQ-032 SHALL cover underflow: shift_in high while extready_out low -> level unchanged and shift_err_out 1 until rst.
REQ-033 SHALL cover simultaneous push and pop at level 2 across pointer wrap for 8 cycles -> level_out constant 2 and data order preserved.
REQ-034 SHALL cover mid-operation reset: rst high one cycle at level 3 -> all outputs at reset values next cycle, ext_ready_out 1 the cycle after.
REQ-035 SHALL cover macro off: single push 0x7FFF after reset -> extready_out 1 and sample_out 0x7FFF 1 cycle after the push.

Source files
------------

// File: rtl/ext_feeder.sv
// ext_feeder: small circular buffer between an external sample producer and
// the controller's data memory. Samples enter on a valid/ready handshake and
// leave when the controller issues a shift while the head sample is valid.
// All outputs are registered and reflect the state after the clock edge.
//
// Build option: define EXT_FEEDER_PREFILL_EN to hold extready_out low until
// the buffer has filled once (PREFILL -> RUN). Without it extready_out follows
// occupancy from reset onward.
//
// state   | meaning
// --------+------------------------------------------------------------
// PREFILL | filling after reset; head never offered to the controller
// RUN     | head offered whenever occupancy is non-zero; held until reset
module ext_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ext_valid_in,
  input  logic [DATA_W-1:0]          ext_data_in,
  output logic                       ext_ready_out,
  input  logic                       shift_in,
  output logic                       extready_out,
  output logic [DATA_W-1:0]          sample_out,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       shift_err_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ext_ready_q, ext_ready_d;
  logic              extready_q, extready_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              shift_err_q, shift_err_d;
  logic              push, pop;

  // Handshakes qualify against the registered outputs the outside world sees.
  always_comb begin
    push        = ext_valid_in && ext_ready_q;
    pop         = shift_in && extready_q;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d     = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    ext_ready_d = (level_d < LVL_FULL);
    shift_err_d = shift_err_q || (shift_in && !extready_q);
    // Next head: bypass the incoming sample when it becomes the head this
    // edge (memory write and head read land on the same entry); hold the
    // last value once the buffer runs empty.
    sample_d    = sample_q;
    if (level_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        sample_d = ext_data_in;
      end else begin
        sample_d = mem_q[rd_ptr_d];
      end
    end
  end

`ifdef EXT_FEEDER_PREFILL_EN
  typedef enum logic {ST_PREFILL, ST_RUN} state_t;
  state_t state_q, state_d;

  // Next state: leave PREFILL the edge the buffer reaches full; RUN is terminal.
  always_comb begin
    state_d    = state_q;
    if ((state_q == ST_PREFILL) && (level_d == LVL_FULL)) begin
      state_d = ST_RUN;
    end
    extready_d = (state_d == ST_RUN) && (level_d != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PREFILL;
    end else begin
      state_q <= state_d;
    end
  end
`else
  // Head valid whenever the buffer holds at least one sample.
  always_comb begin
    extready_d = (level_d != '0);
  end
`endif

  // Buffer storage; no write lands while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= ext_data_in;
    end
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ext_ready_q <= 1'b0;
      extready_q  <= 1'b0;
      sample_q    <= '0;
      shift_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ext_ready_q <= ext_ready_d;
      extready_q  <= extready_d;
      sample_q    <= sample_d;
      shift_err_q <= shift_err_d;
    end
  end

  assign ext_ready_out = ext_ready_q;
  assign extready_out  = extready_q;
  assign sample_out    = sample_q;
  assign level_out     = level_q;
  assign shift_err_out = shift_err_q;

endmodule

// File: tb/tb_ext_feeder.sv
// Directed bench for ext_feeder (DATA_W=16, DEPTH=4). Expectations are
// hand-computed; the prefill-dependent ones follow EXT_FEEDER_PREFILL_EN.
module tb_ext_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_valid_in;
  logic [15:0] ext_data_in;
  logic        ext_ready_out;
  logic        shift_in;
  logic        extready_out;
  logic [15:0] sample_out;
  logic [2:0]  level_out;
  logic        shift_err_out;

  int errs = 0;
  int checks = 0;

  ext_feeder #(.DATA_W(16), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_valid_in  (ext_valid_in),
    .ext_data_in   (ext_data_in),
    .ext_ready_out (ext_ready_out),
    .shift_in      (shift_in),
    .extready_out  (extready_out),
    .sample_out    (sample_out),
    .level_out     (level_out),
    .shift_err_out (shift_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prefill;
`ifdef EXT_FEEDER_PREFILL_EN
    prefill = 1'b1;
`else
    prefill = 1'b0;
`endif
    rst = 1'b1; ext_valid_in = 1'b0; ext_data_in = '0; shift_in = 1'b0;
    tick(); tick();
    check("rst_ext_ready", 32'(ext_ready_out), 0);
    check("rst_extready",  32'(extready_out), 0);
    check("rst_sample",    32'(sample_out), 0);
    check("rst_level",     32'(level_out), 0);
    check("rst_err",       32'(shift_err_out), 0);
    rst = 1'b0;
    tick();
    check("post_rst_ext_ready", 32'(ext_ready_out), 1);

    // Fill 0x0001..0x0004 on consecutive cycles.
    for (int k = 1; k <= 4; k++) begin
      ext_valid_in = 1'b1; ext_data_in = 16'(k);
      tick();
      check($sformatf("fill_level_%0d", k), 32'(level_out), 32'(k));
      check($sformatf("fill_extready_%0d", k), 32'(extready_out),
            (prefill && k < 4) ? 32'd0 : 32'd1);
      check($sformatf("fill_sample_%0d", k), 32'(sample_out), 32'h0001);
    end
    check("full_ext_ready", 32'(ext_ready_out), 0);
    ext_data_in = 16'h0005;
    tick();
    check("full_no_push_level", 32'(level_out), 4);
    check("full_no_push_sample", 32'(sample_out), 32'h0001);

    // Drain in order.
    ext_valid_in = 1'b0; shift_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("drain_level_%0d", k), 32'(level_out), 32'(4 - k));
      check($sformatf("drain_sample_%0d", k), 32'(sample_out), (k < 4) ? 32'(k + 1) : 32'h0004);
      check($sformatf("drain_extready_%0d", k), 32'(extready_out), (k < 4) ? 32'd1 : 32'd0);
    end
    check("drain_ext_ready", 32'(ext_ready_out), 1);
    check("drain_no_err", 32'(shift_err_out), 0);

    // Underflow: shift with nothing offered.
    tick();
    check("uflow_level", 32'(level_out), 0);
    check("uflow_err", 32'(shift_err_out), 1);
    shift_in = 1'b0;

    // Push into empty, then keep level 2 across pointer wrap.
    ext_valid_in = 1'b1; ext_data_in = 16'h0010;
    tick();
    check("empty_push_sample", 32'(sample_out), 32'h0010);
    check("empty_push_extready", 32'(extready_out), prefill ? 32'd1 : 32'd1);
    ext_data_in = 16'h0011;
    tick();
    check("pre_wrap_level", 32'(level_out), 2);
    shift_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ext_data_in = 16'(16'h0012 + i);
      tick();
      check($sformatf("wrap_level_%0d", i), 32'(level_out), 2);
      check($sformatf("wrap_sample_%0d", i), 32'(sample_out), 32'(16'h0011 + i));
    end
    check("wrap_ext_ready", 32'(ext_ready_out), 1);
    check("err_sticky", 32'(shift_err_out), 1);

    // Bring level to 3, then reset for one cycle with handshakes active.
    shift_in = 1'b0; ext_data_in = 16'h0020;
    tick();
    check("pre_rst_level", 32'(level_out), 3);
    rst = 1'b1; shift_in = 1'b1; ext_data_in = 16'h0021;
    tick();
    check("mid_rst_ext_ready", 32'(ext_ready_out), 0);
    check("mid_rst_extready",  32'(extready_out), 0);
    check("mid_rst_sample",    32'(sample_out), 0);
    check("mid_rst_level",     32'(level_out), 0);
    check("mid_rst_err",       32'(shift_err_out), 0);
    rst = 1'b0; ext_valid_in = 1'b0; shift_in = 1'b0;
    tick();
    check("after_rst_ext_ready", 32'(ext_ready_out), 1);
    check("after_rst_level", 32'(level_out), 0);
    check("after_rst_extready", 32'(extready_out), 0);

    // Single push of 0x7FFF after reset.
    ext_valid_in = 1'b1; ext_data_in = 16'h7FFF;
    tick();
    ext_valid_in = 1'b0;
    check("single_sample", 32'(sample_out), 32'h7FFF);
    check("single_extready", 32'(extready_out), prefill ? 32'd0 : 32'd1);
    check("single_level", 32'(level_out), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
